fetch_sequencer: RTL

- Next-PC controller and instruction aligner for the RV32IC fetch stage.
- Drives the PC register's pc_in/hazard_stall from pc_next/pc_hold.
- Selects 16- or 32-bit instructions from the fetched word and stitches 32-bit instructions that straddle a word boundary.
- Arbitrates between branch/jump redirects, instruction-memory stalls and back-end stalls; parks a redirect that arrives while memory is busy.

---
 rtl/fetch_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// RV32IC fetch sequencer: next-PC selection, 16/32-bit instruction alignment,
// word-straddle stitching and redirect parking while instruction memory is busy.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int unsigned BOOT_STALL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic [31:0] imem_rdata,
  input  logic        imem_stall,
  input  logic        be_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        flush_if
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_SPLIT, S_PEND} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_boot_cnt, w_boot_cnt_nxt;
  logic [31:0] r_pend, w_pend_nxt;
  logic [15:0] r_half_buf, w_half_buf_nxt;
  logic [31:0] r_split_pc, w_split_pc_nxt;
  logic [31:0] r_inst_out, w_inst_out_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;
  logic        r_inst_valid, w_inst_valid_nxt;

  logic [15:0] w_sel;
  logic        w_compressed;
  logic [31:0] w_target;
  logic [31:0] w_pc_p2;
  logic [31:0] w_pc_p4;

  assign w_sel        = pc_cur[1] ? imem_rdata[31:16] : imem_rdata[15:0];
  assign w_compressed = (w_sel[1:0] != 2'b11);
  assign w_target     = redirect_target & ~32'd1;
  assign w_pc_p2      = pc_cur + 32'd2;
  assign w_pc_p4      = pc_cur + 32'd4;

  always_comb begin
    w_state_nxt      = r_state;
    w_boot_cnt_nxt   = r_boot_cnt;
    w_pend_nxt       = r_pend;
    w_half_buf_nxt   = r_half_buf;
    w_split_pc_nxt   = r_split_pc;
    w_inst_out_nxt   = r_inst_out;
    w_inst_pc_nxt    = r_inst_pc;
    w_inst_valid_nxt = r_inst_valid;
    pc_next          = pc_cur;
    pc_hold          = 1'b1;
    flush_if         = 1'b0;

    case (r_state)
      S_BOOT: begin
        pc_next = RESET_PC;
        // Leaving on the count-of-one edge gives exactly BOOT_STALL_CYCLES held cycles.
        if (r_boot_cnt <= 32'd1) w_state_nxt = S_RUN;
        if (r_boot_cnt != '0)    w_boot_cnt_nxt = r_boot_cnt - 32'd1;
      end

      S_RUN, S_SPLIT: begin
        if (redirect_valid) begin
          flush_if         = 1'b1;
          w_inst_valid_nxt = 1'b0;
          w_half_buf_nxt   = '0;
          if (imem_stall) begin
            w_pend_nxt  = w_target;
            w_state_nxt = S_PEND;
          end else begin
            pc_next     = w_target;
            pc_hold     = 1'b0;
            w_state_nxt = S_RUN;
          end
        end else if (imem_stall) begin
          w_inst_valid_nxt = 1'b0;
        end else if (be_stall) begin
          w_inst_valid_nxt = r_inst_valid;
        end else if (r_state == S_SPLIT) begin
          w_inst_out_nxt   = {imem_rdata[15:0], r_half_buf};
          w_inst_pc_nxt    = r_split_pc;
          w_inst_valid_nxt = 1'b1;
          pc_next          = w_pc_p2;
          pc_hold          = 1'b0;
          w_state_nxt      = S_RUN;
        end else if (w_compressed) begin
          w_inst_out_nxt   = {16'h0000, w_sel};
          w_inst_pc_nxt    = pc_cur;
          w_inst_valid_nxt = 1'b1;
          pc_next          = w_pc_p2;
          pc_hold          = 1'b0;
        end else if (!pc_cur[1]) begin
          w_inst_out_nxt   = imem_rdata;
          w_inst_pc_nxt    = pc_cur;
          w_inst_valid_nxt = 1'b1;
          pc_next          = w_pc_p4;
          pc_hold          = 1'b0;
        end else begin
          w_half_buf_nxt   = imem_rdata[31:16];
          w_split_pc_nxt   = pc_cur;
          w_inst_valid_nxt = 1'b0;
          pc_next          = w_pc_p2;
          pc_hold          = 1'b0;
          w_state_nxt      = S_SPLIT;
        end
      end

      S_PEND: begin
        w_inst_valid_nxt = 1'b0;
        if (redirect_valid) begin
          flush_if   = 1'b1;
          w_pend_nxt = w_target;
        end
        // A redirect arriving on the release cycle is younger than the parked one.
        if (!imem_stall) begin
          pc_next     = redirect_valid ? w_target : r_pend;
          pc_hold     = 1'b0;
          w_state_nxt = S_RUN;
        end
      end

      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_boot_cnt   <= BOOT_STALL_CYCLES;
      r_pend       <= '0;
      r_half_buf   <= '0;
      r_split_pc   <= '0;
      r_inst_out   <= NOP;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_boot_cnt   <= w_boot_cnt_nxt;
      r_pend       <= w_pend_nxt;
      r_half_buf   <= w_half_buf_nxt;
      r_split_pc   <= w_split_pc_nxt;
      r_inst_out   <= w_inst_out_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_inst_valid_nxt;
    end
  end

  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_inst_valid;

endmodule
